gray_wdt: RTL

GRAY_WDT -- requirements
Module: gray_wdt

---
 rtl/gray_wdt.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gray_wdt.sv
// Gray-code heartbeat watchdog: per-channel lap tracking with sequence and
// timeout fault detection, sticky fault flags and a saturating fault counter.
module gray_wdt #(
    parameter int CH        = 3,
    parameter int W         = 3,
    parameter int TIMEOUT   = 6500000,
    parameter int CNT_W     = 24,
    parameter int GOOD_LAPS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH*W-1:0] hb,
    input  logic            fault_clr,
    output logic [CH-1:0]   health,
    output logic            all_healthy,
    output logic [CH-1:0]   seq_err,
    output logic [CH-1:0]   tmo_err,
    output logic [7:0]      fault_cnt
);

    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [W-1:0]     LAST_CODE = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAPS_MAX  = 4'(GOOD_LAPS);

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int unsigned i = 1; i < W; i++) begin
            b[W-1-i] = b[W-i] ^ g[W-1-i];
        end
        return b;
    endfunction

    logic [CH-1:0] fault_ev;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [W-1:0]     cur_q, prev_q, nxt_bin;
        logic [CNT_W-1:0] timer_q, timer_d;
        logic [3:0]       laps_q, laps_d;
        logic             health_q, health_d;
        logic             seq_q, tmo_q;
        logic             lap, seq_fault, tmo_fault;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= IDLE;
                cur_q    <= '0;
                prev_q   <= '0;
                timer_q  <= '0;
                laps_q   <= '0;
                health_q <= 1'b0;
                seq_q    <= 1'b0;
                tmo_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cur_q    <= hb[c*W +: W];
                prev_q   <= cur_q;
                timer_q  <= timer_d;
                laps_q   <= laps_d;
                health_q <= health_d;
                // A fault raised this cycle overrides a simultaneous clear
                if (seq_fault)      seq_q <= 1'b1;
                else if (fault_clr) seq_q <= 1'b0;
                if (tmo_fault)      tmo_q <= 1'b1;
                else if (fault_clr) tmo_q <= 1'b0;
            end
        end

        always_comb begin
            nxt_bin   = g2b(prev_q) + W'(1);
            state_d   = state_q;
            lap       = 1'b0;
            seq_fault = 1'b0;
            tmo_fault = 1'b0;
            case (state_q)
                IDLE: begin
                    if (cur_q == '0) state_d = TRACK;
                end
                TRACK: begin
                    if (cur_q != prev_q && g2b(cur_q) != nxt_bin) begin
                        seq_fault = 1'b1;
                        state_d   = IDLE;
                    end else if (prev_q == LAST_CODE && cur_q == '0) begin
                        lap = 1'b1;
                    end else if (timer_q == TMO_LAST) begin
                        tmo_fault = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            timer_d = '0;
            laps_d  = '0;
            if (state_q == TRACK && state_d == TRACK) begin
                if (lap) begin
                    laps_d = (laps_q == LAPS_MAX) ? laps_q : laps_q + 4'd1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    laps_d  = laps_q;
                end
            end
            health_d = (state_d == TRACK) && (laps_d == LAPS_MAX);
        end

        assign health[c]   = health_q;
        assign seq_err[c]  = seq_q;
        assign tmo_err[c]  = tmo_q;
        assign fault_ev[c] = seq_fault | tmo_fault;
    end

    assign all_healthy = &health;

    logic [4:0] n_fault;
    logic [8:0] cnt_sum;

    always_comb begin
        n_fault = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            n_fault = n_fault + {4'b0, fault_ev[c]};
        end
        cnt_sum = {1'b0, fault_cnt} + {4'b0, n_fault};
    end

    always_ff @(posedge clk) begin
        if (reset) fault_cnt <= '0;
        else       fault_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end

endmodule
